gen_adder: RTL and testbench



---
 rtl/gen_adder_pkg.sv | 22 ++
 rtl/gen_adder_operand_generator.sv | 32 +++
 rtl/gen_adder_pair_adder.sv | 11 +
 rtl/gen_adder.sv | 34 +++
 tb/tb_gen_adder.sv | 118 +++++++++++
 5 files changed

// File: rtl/gen_adder_pkg.sv
// Shared widths, types and default seeds/steps for the gen_adder operand stream.
package gen_adder_pkg;

  localparam int OPW   = 16;
  localparam int WORDW = 32;

  typedef logic [OPW-1:0]   operand_t;
  typedef logic [WORDW-1:0] word_t;

  localparam operand_t DEF_A_SEED = 16'h0000;
  localparam operand_t DEF_B_SEED = 16'h0000;
  localparam operand_t DEF_A_STEP = 16'h0001;
  localparam operand_t DEF_B_STEP = 16'h0002;

  // Full-precision unsigned sum of the two halves of a stream word, zero-extended.
  function automatic word_t pairSum(input word_t word);
    logic [OPW:0] sum;
    sum = {1'b0, word[OPW-1:0]} + {1'b0, word[WORDW-1:OPW]};
    return {{(WORDW-OPW-1){1'b0}}, sum};
  endfunction

endpackage

// File: rtl/gen_adder_operand_generator.sv
// Stepping operand generator: two wrapping counters snapshotted into the stream word.
module operand_generator
  import gen_adder_pkg::*;
#(
  parameter operand_t A_SEED = DEF_A_SEED,
  parameter operand_t B_SEED = DEF_B_SEED,
  parameter operand_t A_STEP = DEF_A_STEP,
  parameter operand_t B_STEP = DEF_B_STEP
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  output word_t out
);

  operand_t cntA;
  operand_t cntB;

  // An unknown enable falls to the else path, so the stream never advances on X.
  always_ff @(posedge clk) begin
    if (rst) begin
      cntA <= A_SEED;
      cntB <= B_SEED;
      out  <= '0;
    end else if (enable == 1'b1) begin
      out  <= {cntB, cntA};
      cntA <= cntA + A_STEP;
      cntB <= cntB + B_STEP;
    end
  end

endmodule

// File: rtl/gen_adder_pair_adder.sv
// Combinational adder of the two 16-bit operands packed in a stream word.
module pair_adder
  import gen_adder_pkg::*;
(
  input  word_t word,
  output word_t result
);

  assign result = pairSum(word);

endmodule

// File: rtl/gen_adder.sv
// Top level: operand generator feeding a zero-latency pair adder.
module gen_adder
  import gen_adder_pkg::*;
#(
  parameter operand_t A_SEED = DEF_A_SEED,
  parameter operand_t B_SEED = DEF_B_SEED,
  parameter operand_t A_STEP = DEF_A_STEP,
  parameter operand_t B_STEP = DEF_B_STEP
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  output word_t out,
  output word_t result
);

  operand_generator #(
    .A_SEED(A_SEED),
    .B_SEED(B_SEED),
    .A_STEP(A_STEP),
    .B_STEP(B_STEP)
  ) uGenerator (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .out   (out)
  );

  pair_adder uAdder (
    .word  (out),
    .result(result)
  );

endmodule

// File: tb/tb_gen_adder.sv
// Directed bench for gen_adder: default stream plus a wrap-around seeded instance.
module tb_gen_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] out0, result0;
  logic [31:0] out1, result1;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  gen_adder dut0 (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .out   (out0),
    .result(result0)
  );

  gen_adder #(
    .A_SEED(16'hFFFF),
    .B_SEED(16'hFFFF),
    .A_STEP(16'h0001),
    .B_STEP(16'h0001)
  ) dut1 (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .out   (out1),
    .result(result1)
  );

  // Inputs change on the falling edge; outputs are sampled just after the last rising edge.
  task automatic applyStimulus(input logic rstV, input logic enV, input int cycles);
    @(negedge clk);
    rst    = rstV;
    enable = enV;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obsOut,
                             input logic [31:0] obsRes, input logic [31:0] expOut,
                             input logic [31:0] expRes);
    checkCount++;
    assert (obsOut === expOut) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s out: got 0x%08h, expected 0x%08h", tag, obsOut, expOut);
    end
    checkCount++;
    assert (obsRes === expRes) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s result: got 0x%08h, expected 0x%08h", tag, obsRes, expRes);
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;

    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("reset_dflt", out0, result0, 32'h0000_0000, 32'h0000_0000);
    checkOutput("reset_wrap", out1, result1, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("en1_dflt", out0, result0, 32'h0000_0000, 32'h0000_0000);
    checkOutput("en1_wrap", out1, result1, 32'hFFFF_FFFF, 32'h0001_FFFE);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("en2_dflt", out0, result0, 32'h0002_0001, 32'h0000_0003);
    checkOutput("en2_wrap", out1, result1, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("en3_dflt", out0, result0, 32'h0004_0002, 32'h0000_0006);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("en4_dflt", out0, result0, 32'h0006_0003, 32'h0000_0009);

    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("hold_dflt", out0, result0, 32'h0006_0003, 32'h0000_0009);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("resume_dflt", out0, result0, 32'h0008_0004, 32'h0000_000C);

    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("en10_dflt", out0, result0, 32'h0012_0009, 32'h0000_001B);

    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midreset", out0, result0, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restart1", out0, result0, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("restart2", out0, result0, 32'h0002_0001, 32'h0000_0003);

    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'bx, 3);
    checkOutput("enx_dflt", out0, result0, 32'h0000_0000, 32'h0000_0000);
    checkOutput("enx_wrap", out1, result1, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("afterx1", out0, result0, 32'h0000_0000, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("afterx2", out0, result0, 32'h0002_0001, 32'h0000_0003);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
